// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the hazard controller
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int DEFAULT_MULT_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    // Memory stage wins over writeback since it carries the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wreg_m,
        input logic       rw_m,
        input logic [4:0] wreg_w,
        input logic       rw_w
    );
        if (src != 5'd0 && src == wreg_m && rw_m)
            return FWD_M;
        else if (src != 5'd0 && src == wreg_w && rw_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - multi-cycle multiplier sequencing FSM and countdown
module mult_sequencer
    import hazard_pkg::*;
#(
    parameter int MULT_LATENCY = DEFAULT_MULT_LATENCY,
    parameter int CNT_W        = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mult_e,
    output logic o_mult_start,
    output logic o_mult_busy
);

    mult_state_t      r_state;
    mult_state_t      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // DONE behaves like IDLE for a new start; MultE while BUSY is ignored.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_mult_e) begin
                    w_start      = 1'b1;
                    w_cnt_next   = CNT_W'(MULT_LATENCY - 1);
                    w_state_next = ST_BUSY;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0)
                    w_state_next = ST_DONE;
                else
                    w_cnt_next = r_cnt - CNT_W'(1);
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_mult_start = w_start & i_rst_n;
    assign o_mult_busy  = (r_state == ST_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush/forward control; HAZARD_PERF_CNT_EN adds stall counters
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MULT_LATENCY = DEFAULT_MULT_LATENCY,
    parameter int CNT_W        = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic        JumpD,
    input  logic        MultE,
    input  logic        HiLoReadD,
    output logic        StallF,
    output logic        StallD,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] StallCount,
    output logic [15:0] MultStallCount,
`endif
    output logic        MultStart,
    output logic        MultBusy
);

    logic w_mult_start;
    logic w_mult_busy;
    logic w_lwstall;
    logic w_branchstall;
    logic w_multstall;
    logic w_stall;
    logic w_redirect;

    mult_sequencer #(
        .MULT_LATENCY (MULT_LATENCY),
        .CNT_W        (CNT_W)
    ) u_mult_seq (
        .i_clk        (Clk),
        .i_rst_n      (Rst_n),
        .i_mult_e     (MultE),
        .o_mult_start (w_mult_start),
        .o_mult_busy  (w_mult_busy)
    );

    assign w_lwstall     = MemtoRegE && (RtE == RsD || RtE == RtD);
    assign w_branchstall = BranchD &&
                           ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                            (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    assign w_multstall   = w_mult_busy && HiLoReadD;
    assign w_stall       = (w_lwstall | w_branchstall | w_multstall) & Rst_n;
    assign w_redirect    = (PCSrcD | JumpD) & Rst_n;

    // Combinational paths are gated so every output reads zero during reset.
    assign StallF    = w_stall;
    assign StallD    = w_stall;
    assign FlushE    = w_stall;
    assign FlushD    = w_redirect & ~w_stall;
    assign StallM    = 1'b0;
    assign ForwardAD = Rst_n && RsD != 5'd0 && RsD == WriteRegM && RegWriteM;
    assign ForwardBD = Rst_n && RtD != 5'd0 && RtD == WriteRegM && RegWriteM;
    assign ForwardAE = {2{Rst_n}} & fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign ForwardBE = {2{Rst_n}} & fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
    assign MultStart = w_mult_start;
    assign MultBusy  = w_mult_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_mult_stall_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt      <= '0;
            r_mult_stall_cnt <= '0;
        end else begin
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_multstall && r_mult_stall_cnt != '1)
                r_mult_stall_cnt <= r_mult_stall_cnt + 16'd1;
        end
    end

    assign StallCount     = r_stall_cnt;
    assign MultStallCount = r_mult_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD, JumpD, MultE, HiLoReadD;
    logic       StallF, StallD, StallM, FlushD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MultStart, MultBusy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCount;
    logic [15:0] MultStallCount;
`endif

    int total  = 0;
    int passed = 0;

    hazard_controller #(.MULT_LATENCY(4), .CNT_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
        .MultE(MultE), .HiLoReadD(HiLoReadD),
        .StallF(StallF), .StallD(StallD), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_CNT_EN
        .StallCount(StallCount), .MultStallCount(MultStallCount),
`endif
        .MultStart(MultStart), .MultBusy(MultBusy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; PCSrcD = 0; JumpD = 0; MultE = 0; HiLoReadD = 0;
    endtask

    initial begin
        Rst_n = 1'b0;
        clear_inputs();
        RsE = 8; RegWriteM = 1; WriteRegM = 8; MemtoRegE = 1; RtE = 9; RtD = 9;
        PCSrcD = 1; MultE = 1; RsD = 8;
        #1;
        check("rst_fwdAE", ForwardAE, 2'b00);
        check("rst_fwdAD", ForwardAD, 1'b0);
        check("rst_stallD", StallD, 1'b0);
        check("rst_flushD", FlushD, 1'b0);
        check("rst_multstart", MultStart, 1'b0);
        check("rst_multbusy", MultBusy, 1'b0);

        @(negedge Clk); Rst_n = 1'b1; clear_inputs();
        RegWriteM = 1; WriteRegM = 8; RsE = 8; RtE = 3; RegWriteW = 1; WriteRegW = 8;
        #1;
        check("fwdAE_m_prio", ForwardAE, 2'b10);
        check("fwdBE_none", ForwardBE, 2'b00);
        check("stallM_zero", StallM, 1'b0);
        RsE = 0; #1;
        check("fwdAE_r0", ForwardAE, 2'b00);
        RegWriteM = 0; RsE = 8; RtE = 8; #1;
        check("fwdAE_w", ForwardAE, 2'b01);
        check("fwdBE_w", ForwardBE, 2'b01);
        RegWriteM = 1; RsD = 8; RtD = 8; #1;
        check("fwdAD", ForwardAD, 1'b1);
        check("fwdBD", ForwardBD, 1'b1);
        check("no_stall_fwd", StallD, 1'b0);

        @(negedge Clk); clear_inputs();
        MemtoRegE = 1; RtE = 9; RtD = 9; #1;
        check("lw_stallF", StallF, 1'b1);
        check("lw_stallD", StallD, 1'b1);
        check("lw_flushE", FlushE, 1'b1);
        @(negedge Clk); MemtoRegE = 0; #1;
        check("lw_end_stallF", StallF, 1'b0);
        check("lw_end_flushE", FlushE, 1'b0);

        @(negedge Clk); clear_inputs();
        BranchD = 1; RsD = 5; RegWriteE = 1; WriteRegE = 5; #1;
        check("br_stall_e", StallD, 1'b1);
        @(negedge Clk); RegWriteE = 0; WriteRegE = 0; WriteRegM = 5; RegWriteM = 1; MemtoRegM = 0; #1;
        check("br_fwdAD", ForwardAD, 1'b1);
        check("br_nostall", StallD, 1'b0);
        @(negedge Clk); clear_inputs();
        BranchD = 1; RtD = 7; MemtoRegM = 1; WriteRegM = 7; #1;
        check("br_stall_ldm", StallF, 1'b1);

        @(negedge Clk); clear_inputs();
        MemtoRegE = 1; RtE = 9; RsD = 9; PCSrcD = 1; #1;
        check("redir_stall_wins", FlushD, 1'b0);
        check("redir_stalled", StallD, 1'b1);
        @(negedge Clk); MemtoRegE = 0; #1;
        check("redir_taken", FlushD, 1'b1);
        PCSrcD = 0; JumpD = 1; #1;
        check("jump_flush", FlushD, 1'b1);

        @(negedge Clk); clear_inputs();
        MultE = 1; #1;
        check("mult_c0_start", MultStart, 1'b1);
        check("mult_c0_busy", MultBusy, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk); MultE = 0; HiLoReadD = 1; #1;
            check($sformatf("mult_c%0d_busy", c), MultBusy, 1'b1);
            check($sformatf("mult_c%0d_stallD", c), StallD, 1'b1);
            check($sformatf("mult_c%0d_start", c), MultStart, 1'b0);
        end
        @(negedge Clk); #1;
        check("mult_c5_busy", MultBusy, 1'b0);
        check("mult_c5_stallD", StallD, 1'b0);
        check("mult_c5_start", MultStart, 1'b0);
        MultE = 1; #1;
        check("mult_done_restart", MultStart, 1'b1);
        @(negedge Clk); MultE = 0; #1;
        check("mult_restart_busy", MultBusy, 1'b1);
        MultE = 1; #1;
        check("mult_busy_ignore", MultStart, 1'b0);
        @(negedge Clk); MultE = 0; #1;
        check("mult_still_busy", MultBusy, 1'b1);
        #2 Rst_n = 1'b0; #1;
        check("async_rst_busy", MultBusy, 1'b0);
        check("async_rst_stall", StallD, 1'b0);
        @(negedge Clk); Rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("post_rst_start%0d", c), MultStart, 1'b0);
            check($sformatf("post_rst_busy%0d", c), MultBusy, 1'b0);
            @(negedge Clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central hazard and sequencing unit for the 5-stage MIPS pipeline. Drives stall enables and clears for the F/D, D/E and E/M pipeline registers, and generates forwarding selects for the decode-stage branch comparator and the execute-stage ALU/Mult operands. Owns a small FSM that sequences the multi-cycle multiplier and holds dependent instructions until the HI/LO result is valid. Purely control; no datapath values pass through it.

Parameters:
MULT_LATENCY, 4, cycles the multiplier needs from MultStart to a valid HI/LO; legal range 2..15
CNT_W, 4, width of the multiplier countdown counter; must satisfy 2^CNT_W > MULT_LATENCY

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
RsD, RtD  in  5 each  decode source registers
RsE, RtE  in  5 each  execute source registers
WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write control per stage
MemtoRegE, MemtoRegM  in  1 each  load in E / M
BranchD  in  1  branch in decode
PCSrcD  in  1  branch taken, resolved in decode
JumpD  in  1  jump in decode
MultE  in  1  mult/multu in execute
HiLoReadD  in  1  mfhi/mflo in decode
StallF, StallD  out  1 each  hold the PC / F-D register
StallM  out  1  E/M register En (1 = hold)
FlushD, FlushE  out  1 each  synchronous Clr to the F-D / D-E register
ForwardAD, ForwardBD  out  1 each  1 = take ExecuteOutM for the branch compare
ForwardAE, ForwardBE  out  2 each  00 register file, 01 result W, 10 ExecuteOutM
MultStart  out  1  one-cycle start pulse to the multiplier
MultBusy  out  1  multiplier in flight

Behaviour:
- Reset (Rst_n=0, asynchronous): FSM to IDLE, counter 0. Every output reads 0 while in reset.
- Forwarding is combinational.
  - ForwardAE = 10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 01 if RsE!=0 && RsE==WriteRegW && RegWriteW; else 00. M takes priority over W.
  - ForwardBE uses RtE with the same rule.
  - ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD uses RtD with the same rule.
- lwstall = MemtoRegE && (RsE==RtD || RtE==RtD ... specifically RtE==RsD || RtE==RtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- Mult FSM states: IDLE, BUSY, DONE.
  - IDLE: if MultE, assert MultStart for that cycle, load counter with MULT_LATENCY-1, go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter reaches 0, go to DONE.
  - DONE: lasts one cycle (HI/LO written), then IDLE. If MultE is asserted in DONE, behave as from IDLE: start a new multiply and go directly to BUSY.
  - MultBusy = (state==BUSY).
- multstall = MultBusy && HiLoReadD. A new multiply entering E while BUSY is not possible because a second mult in D also raises multstall; treat MultE in BUSY as an illegal input and ignore it.
- Outputs:
  - StallF = StallD = lwstall | branchstall | multstall.
  - FlushE = same OR.
  - FlushD = (PCSrcD | JumpD) and not StallD. A stall wins over a redirect; the redirect is retaken next cycle.
  - StallM = 0 always in this revision.
- Simultaneous events: lwstall and multstall together give a single stall. The FSM advances regardless of stalls.
- Reset during BUSY aborts the multiply. No MultStart is generated after reset.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output StallCount (32-bit). It increments by 1 every cycle StallD=1, saturates at 0xFFFFFFFF, and resets to 0 on Rst_n. It also adds output MultStallCount (16-bit) with the same rules, counting multstall cycles.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - the mult FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - the default MULT_LATENCY
- One sub-module: mult_sequencer, containing the FSM, counter, MultStart and MultBusy.
- Forwarding and stall logic stay in the top level.

Test Plan:
- RegWriteM=1, WriteRegM=8, RsE=8, plus RegWriteW=1, WriteRegW=8 -> ForwardAE=10. With RsE=0 and the same setup -> ForwardAE=00.
- MemtoRegE=1, RtE=9, RtD=9 -> StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle (MemtoRegE deasserted) all are 0.
- BranchD=1, RsD=5, RegWriteE=1, WriteRegE=5 -> stall 1 cycle. Then WriteRegM=5, MemtoRegM=0 -> ForwardAD=1, no stall.
- MultE pulse at cycle 0 with MULT_LATENCY=4 -> MultStart=1 at cycle 0, MultBusy=1 for cycles 1-4, DONE at cycle 5. HiLoReadD held high -> StallD=1 cycles 1-4, 0 at cycle 5.
- PCSrcD=1 with lwstall active -> FlushD=0. Next cycle, no stall -> FlushD=1.
- Rst_n pulled low mid-BUSY, asynchronously -> MultBusy=0 immediately, IDLE. After release with no MultE -> MultStart stays 0.
